sdram_req_bridge: RTL and testbench

- Converts the core's single-outstanding SDRAM request bus (sdram_read/sdram_write/sdram_addr/sdram_writedata, sdram_readdata/sdram_finished) into Avalon-MM master cycles on the new_sdram_controller_0 s1 slave.
- Sits directly downstream of the core's request mux, between it and the SDRAM controller.
- Handles waitrequest stalls and pipelined readdatavalid returns.
- Bounds each read with a watchdog so that no client core can hang.

---
 rtl/sdram_pkg.sv | 12 +
 rtl/sdram_req_bridge.sv | 151 +++++++++++++++
 tb/tb_sdram_req_bridge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request bridge.
// Holds the bridge state encoding and the default bus widths.
package sdram_pkg;

    typedef enum logic [2:0] {IDLE, WR, RD, RDW, DONE} bridge_state_t;

    localparam int SDRAM_ADDR_W = 23;
    localparam int SDRAM_DATA_W = 32;

    localparam logic [3:0] BE_ALL_N = 4'b0000;

endpackage

// File: rtl/sdram_req_bridge.sv
// Bridges the core's single-outstanding SDRAM request bus onto the Avalon-MM
// s1 slave of the SDRAM controller, with a read watchdog so no client can hang.
module sdram_req_bridge
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = SDRAM_ADDR_W,
    parameter int DATA_W     = SDRAM_DATA_W,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              sdram_read,
    input  logic              sdram_write,
    input  logic [ADDR_W-1:0] sdram_addr,
    input  logic [DATA_W-1:0] sdram_writedata,
    output logic [DATA_W-1:0] sdram_readdata,
    output logic              sdram_finished,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [ADDR_W-1:0] new_sdram_controller_0_s1_address,
    output logic [3:0]        new_sdram_controller_0_s1_byteenable_n,
    output logic              new_sdram_controller_0_s1_chipselect,
    output logic [DATA_W-1:0] new_sdram_controller_0_s1_writedata,
    output logic              new_sdram_controller_0_s1_read_n,
    output logic              new_sdram_controller_0_s1_write_n,
    input  logic [DATA_W-1:0] new_sdram_controller_0_s1_readdata,
    input  logic              new_sdram_controller_0_s1_readdatavalid,
    input  logic              new_sdram_controller_0_s1_waitrequest
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    // The counter reads 1 in the first RDW cycle, so the last waiting cycle holds RD_TIMEOUT-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

    bridge_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cs_q, cs_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              fin_q, fin_d;
    logic              to_q, to_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            fin_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            fin_q   <= fin_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        fin_d   = 1'b0;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (sdram_write) begin
                    addr_d  = sdram_addr;
                    wdata_d = sdram_writedata;
                    cs_d    = 1'b1;
                    wr_n_d  = 1'b0;
                    state_d = WR;
                end else if (sdram_read) begin
                    addr_d  = sdram_addr;
                    cs_d    = 1'b1;
                    rd_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            WR: begin
                if (!new_sdram_controller_0_s1_waitrequest) begin
                    cs_d    = 1'b0;
                    wr_n_d  = 1'b1;
                    fin_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RD: begin
                if (!new_sdram_controller_0_s1_waitrequest) begin
                    cs_d   = 1'b0;
                    rd_n_d = 1'b1;
                    cnt_d  = CNT_W'(1);
                    // A zero-latency return completes straight from the acceptance cycle.
                    if (new_sdram_controller_0_s1_readdatavalid) begin
                        rdata_d = new_sdram_controller_0_s1_readdata;
                        fin_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RDW;
                    end
                end
            end
            RDW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (new_sdram_controller_0_s1_readdatavalid) begin
                    rdata_d = new_sdram_controller_0_s1_readdata;
                    fin_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q >= TO_LAST) begin
                    rdata_d = '0;
                    to_d    = 1'b1;
                    fin_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sdram_readdata                         = rdata_q;
    assign sdram_finished                         = fin_q;
    assign o_busy                                 = (state_q != IDLE);
    assign o_timeout                              = to_q;
    assign new_sdram_controller_0_s1_address      = addr_q;
    assign new_sdram_controller_0_s1_byteenable_n = BE_ALL_N;
    assign new_sdram_controller_0_s1_chipselect   = cs_q;
    assign new_sdram_controller_0_s1_writedata    = wdata_q;
    assign new_sdram_controller_0_s1_read_n       = rd_n_q;
    assign new_sdram_controller_0_s1_write_n      = wr_n_q;

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed plus randomized bench for sdram_req_bridge, checked against a
// transaction-level timing model of the request/Avalon handshake.
module tb_sdram_req_bridge;

    localparam int AW   = 23;
    localparam int DW   = 32;
    localparam int RDTO = 15;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          sdram_read = 1'b0;
    logic          sdram_write = 1'b0;
    logic [AW-1:0] sdram_addr = '0;
    logic [DW-1:0] sdram_writedata = '0;
    logic [DW-1:0] sdram_readdata;
    logic          sdram_finished;
    logic          o_busy;
    logic          o_timeout;
    logic [AW-1:0] s1_address;
    logic [3:0]    s1_be_n;
    logic          s1_cs;
    logic [DW-1:0] s1_wdata;
    logic          s1_read_n;
    logic          s1_write_n;
    logic [DW-1:0] s1_readdata = '0;
    logic          s1_rdv = 1'b0;
    logic          s1_wait = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: the readdata register and the sticky watchdog flag.
    logic [DW-1:0] rdata_model = '0;
    logic          to_model = 1'b0;

    always #5 i_clk = ~i_clk;

    sdram_req_bridge #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .RD_TIMEOUT(RDTO)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .sdram_read(sdram_read),
        .sdram_write(sdram_write),
        .sdram_addr(sdram_addr),
        .sdram_writedata(sdram_writedata),
        .sdram_readdata(sdram_readdata),
        .sdram_finished(sdram_finished),
        .o_busy(o_busy),
        .o_timeout(o_timeout),
        .new_sdram_controller_0_s1_address(s1_address),
        .new_sdram_controller_0_s1_byteenable_n(s1_be_n),
        .new_sdram_controller_0_s1_chipselect(s1_cs),
        .new_sdram_controller_0_s1_writedata(s1_wdata),
        .new_sdram_controller_0_s1_read_n(s1_read_n),
        .new_sdram_controller_0_s1_write_n(s1_write_n),
        .new_sdram_controller_0_s1_readdata(s1_readdata),
        .new_sdram_controller_0_s1_readdatavalid(s1_rdv),
        .new_sdram_controller_0_s1_waitrequest(s1_wait)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_read_n"}, 64'(s1_read_n), 64'd1);
        chk({tag, "_write_n"}, 64'(s1_write_n), 64'd1);
        chk({tag, "_cs"}, 64'(s1_cs), 64'd0);
        chk({tag, "_addr"}, 64'(s1_address), 64'd0);
        chk({tag, "_wdata"}, 64'(s1_wdata), 64'd0);
        chk({tag, "_fin"}, 64'(sdram_finished), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
    endtask

    // One client transaction. The slave stalls for 'stall' cycles, returns read data
    // 'lat' cycles after acceptance; 'extra' keeps the request held that many cycles
    // past finished (only used with writes, where it re-issues the write).
    task automatic run_txn(input string tag, input bit do_wr, input bit do_rd,
                           input logic [AW-1:0] a_in, input logic [DW-1:0] d_in,
                           input int stall, input int lat, input int extra);
        int acc, exp_fin, fin_cyc, nfin, nwr, nrd, badbus, last;
        logic [DW-1:0] rd_val, exp_rd, fin_rd;
        logic fin_to, exp_to, is_wr;
        is_wr   = do_wr;
        acc     = 1 + stall;
        rd_val  = $urandom;
        exp_fin = is_wr ? acc + 1 : acc + 1 + ((lat < RDTO - 1) ? lat : RDTO - 1);
        exp_rd  = is_wr ? rdata_model : ((lat >= RDTO) ? '0 : rd_val);
        exp_to  = to_model | (!is_wr && lat >= RDTO);
        fin_cyc = -1;
        nfin = 0; nwr = 0; nrd = 0; badbus = 0;
        fin_rd = '0; fin_to = 1'b0;
        last = exp_fin + 6;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                sdram_write     = do_wr;
                sdram_read      = do_rd;
                sdram_addr      = a_in;
                sdram_writedata = d_in;
            end else if (fin_cyc >= 0 && k == fin_cyc + 1 + extra) begin
                sdram_write = 1'b0;
                sdram_read  = 1'b0;
            end else if (extra == 0 && fin_cyc < 0) begin
                sdram_addr      = AW'($urandom);
                sdram_writedata = $urandom;
            end
            s1_wait     = (k < acc);
            s1_rdv      = (!is_wr && k == acc + lat);
            s1_readdata = s1_rdv ? rd_val : DW'($urandom);
            @(negedge i_clk);
            if (!s1_write_n) begin
                nwr++;
                if (s1_address !== a_in || s1_wdata !== d_in || s1_cs !== 1'b1) badbus++;
            end
            if (!s1_read_n) begin
                nrd++;
                if (s1_address !== a_in || s1_cs !== 1'b1) badbus++;
            end
            if (sdram_finished) begin
                nfin++;
                if (fin_cyc < 0) begin
                    fin_cyc = k;
                    fin_rd  = sdram_readdata;
                    fin_to  = o_timeout;
                end
            end
            @(posedge i_clk);
            #1;
        end
        s1_rdv  = 1'b0;
        s1_wait = 1'b0;
        chk({tag, "_fin_cycle"}, 64'(fin_cyc), 64'(exp_fin));
        chk({tag, "_fin_count"}, 64'(nfin), 64'((is_wr && extra > 0) ? 2 : 1));
        chk({tag, "_write_n_cycles"}, 64'(nwr), 64'(is_wr ? acc + ((extra > 0) ? 1 : 0) : 0));
        chk({tag, "_read_n_cycles"}, 64'(nrd), 64'(is_wr ? 0 : acc));
        chk({tag, "_bus_values"}, 64'(badbus), 64'd0);
        chk({tag, "_readdata"}, 64'(fin_rd), 64'(exp_rd));
        chk({tag, "_timeout"}, 64'(fin_to), 64'(exp_to));
        chk({tag, "_idle_after"}, 64'(o_busy), 64'd0);
        chk({tag, "_be_n"}, 64'(s1_be_n), 64'd0);
        rdata_model = exp_rd;
        to_model    = exp_to;
    endtask

    task automatic reset_mid_read();
        int nfin;
        nfin = 0;
        sdram_read = 1'b1;
        sdram_addr = 23'h00ABCD;
        s1_wait    = 1'b0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        chk("rstmid_busy_before", 64'(o_busy), 64'd1);
        i_rst      = 1'b0;
        sdram_read = 1'b0;
        #1;
        chk_reset_values("rstmid");
        chk("rstmid_readdata", 64'(sdram_readdata), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk);
            #1;
            s1_rdv      = (k == 1);
            s1_readdata = 32'hCAFEF00D;
            @(negedge i_clk);
            if (sdram_finished) nfin++;
        end
        @(posedge i_clk);
        #1;
        s1_rdv = 1'b0;
        chk("rstmid_no_finish", 64'(nfin), 64'd0);
        chk("rstmid_readdata_after", 64'(sdram_readdata), 64'd0);
        chk("rstmid_idle_after", 64'(o_busy), 64'd0);
        chk("rstmid_read_n_after", 64'(s1_read_n), 64'd1);
        rdata_model = '0;
        to_model    = 1'b0;
    endtask

    initial begin
        int kind, stall, lat;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk_reset_values("reset");
        chk("reset_readdata", 64'(sdram_readdata), 64'd0);
        chk("reset_be_n", 64'(s1_be_n), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        run_txn("wr_nostall", 1'b1, 1'b0, 23'h000010, 32'hDEADBEEF, 0, 0, 0);
        run_txn("rd_stall", 1'b0, 1'b1, 23'h7FFFFF, 32'h0, 3, 4, 0);
        run_txn("both", 1'b1, 1'b1, 23'h000005, 32'h55AA55AA, 0, 0, 0);
        run_txn("held_wr", 1'b1, 1'b0, 23'h001234, 32'h0BADF00D, 0, 0, 1);
        reset_mid_read();
        run_txn("rd_timeout", 1'b0, 1'b1, 23'h000321, 32'h0, 0, 40, 0);
        run_txn("rd_lat14", 1'b0, 1'b1, 23'h000400, 32'h0, 1, RDTO - 1, 0);
        run_txn("rd_lat15", 1'b0, 1'b1, 23'h000401, 32'h0, 2, RDTO, 0);
        run_txn("rd_lat0", 1'b0, 1'b1, 23'h000402, 32'h0, 0, 0, 0);
        run_txn("wr_stall", 1'b1, 1'b0, 23'h400000, 32'h13579BDF, 2, 0, 0);

        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(0, 2);
            stall = $urandom_range(0, 3);
            lat   = $urandom_range(0, 18);
            run_txn($sformatf("rand%0d", i), kind != 1, kind != 0,
                    AW'($urandom), $urandom, stall, lat, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
